control_sequencer: RTL and testbench

//  Multi-cycle fetch/decode/execute FSM for the 4-bit processor. Drives the program

---
 rtl/control_sequencer_if.sv | 50 +++++
 rtl/control_sequencer.sv | 91 +++++++++
 tb/tb_control_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: sequencer <-> memory/PC/datapath bundle.
//   instr      program memory read data at current PC
//   zero_flag  accumulator == 0
//   carry_flag carry/borrow of last ALU op
//   mem_rd     program memory read strobe
//   pc_enable  PC increment request
//   pc_load    PC parallel-load request
//   pc_in      PC load value
//   acc_load   accumulator write strobe
//   alu_op     0 PASS, 1 ADD, 2 SUB, 3 AND, 4 OR
//   operand    IR operand field
//   halted     1 while halted
//   step, run  single-step controls (only with SINGLE_STEP_EN)
interface control_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int OPW   = 4
);
    logic [OPW+WIDTH-1:0] instr;
    logic                 zero_flag;
    logic                 carry_flag;
    logic                 mem_rd;
    logic                 pc_enable;
    logic                 pc_load;
    logic [WIDTH-1:0]     pc_in;
    logic                 acc_load;
    logic [2:0]           alu_op;
    logic [WIDTH-1:0]     operand;
    logic                 halted;
`ifdef SINGLE_STEP_EN
    logic                 step;
    logic                 run;
    modport master (
        input  instr, zero_flag, carry_flag, step, run,
        output mem_rd, pc_enable, pc_load, pc_in, acc_load, alu_op, operand, halted
    );
    modport slave (
        output instr, zero_flag, carry_flag, step, run,
        input  mem_rd, pc_enable, pc_load, pc_in, acc_load, alu_op, operand, halted
    );
`else
    modport master (
        input  instr, zero_flag, carry_flag,
        output mem_rd, pc_enable, pc_load, pc_in, acc_load, alu_op, operand, halted
    );
    modport slave (
        output instr, zero_flag, carry_flag,
        input  mem_rd, pc_enable, pc_load, pc_in, acc_load, alu_op, operand, halted
    );
`endif
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/decode/execute FSM of the 4-bit processor.
//   clk    rising-edge clock
//   reset  synchronous active-high reset; gates every output to 0
//   bus    control_sequencer_if.master (memory, PC and datapath signals)
// Optional feature macro SINGLE_STEP_EN: adds bus.step/bus.run and a WAIT state
// that holds the FSM between instructions unless run or step is high.
module control_sequencer #(
    parameter int WIDTH = 4,
    parameter int OPW   = 4
) (
    input logic                 clk,
    input logic                 reset,
    control_sequencer_if.master bus
);
    localparam logic [OPW-1:0] OP_LDA = OPW'(1);
    localparam logic [OPW-1:0] OP_OR  = OPW'(5);
    localparam logic [OPW-1:0] OP_JMP = OPW'(6);
    localparam logic [OPW-1:0] OP_JZ  = OPW'(7);
    localparam logic [OPW-1:0] OP_JC  = OPW'(8);
    localparam logic [OPW-1:0] OP_HLT = '1;

`ifdef SINGLE_STEP_EN
    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, HALT, WAIT} state_t;
    localparam state_t START = WAIT;
`else
    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, HALT} state_t;
    localparam state_t START = FETCH;
`endif

    state_t               state, state_nx, resume;
    logic [OPW+WIDTH-1:0] ir;
    logic [OPW-1:0]       op;
    logic                 is_alu, taken;

    assign op     = ir[OPW+WIDTH-1:WIDTH];
    assign is_alu = op >= OP_LDA && op <= OP_OR;
    assign taken  = op == OP_JMP || (op == OP_JZ && bus.zero_flag) || (op == OP_JC && bus.carry_flag);

    // State entered after a completed instruction (and left from WAIT).
`ifdef SINGLE_STEP_EN
    assign resume = (bus.run || bus.step) ? FETCH : WAIT;
`else
    assign resume = FETCH;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= START;
            ir    <= '0;
        end else begin
            state <= state_nx;
            if (state == FETCH)
                ir <= bus.instr;
        end
    end

    // Every strobe is qualified with !reset so nothing escapes in the reset cycle.
    always_comb begin
        state_nx      = state;
        bus.mem_rd    = 1'b0;
        bus.pc_enable = 1'b0;
        bus.pc_load   = 1'b0;
        bus.pc_in     = '0;
        bus.acc_load  = 1'b0;
        bus.alu_op    = 3'd0;
        bus.halted    = 1'b0;
        bus.operand   = reset ? '0 : ir[WIDTH-1:0];
        case (state)
            FETCH: begin
                state_nx      = DECODE;
                bus.mem_rd    = !reset;
                bus.pc_enable = !reset;
            end
            DECODE: state_nx = EXECUTE;
            EXECUTE: begin
                state_nx     = (op == OP_HLT) ? HALT : resume;
                bus.acc_load = !reset && is_alu;
                bus.alu_op   = (!reset && is_alu) ? 3'(op - OP_LDA) : 3'd0;
                bus.pc_load  = !reset && taken;
                bus.pc_in    = (!reset && taken) ? ir[WIDTH-1:0] : '0;
                // The HLT execute cycle already reports halted.
                bus.halted   = !reset && op == OP_HLT;
            end
            HALT: bus.halted = !reset;
`ifdef SINGLE_STEP_EN
            WAIT: state_nx = resume;
`endif
            default: state_nx = START;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: instruction-level model check plus directed program scenarios.
module tb_control_sequencer;
    localparam int PH_F = 0, PH_D = 1, PH_E = 2, PH_H = 3, PH_W = 4;
`ifdef SINGLE_STEP_EN
    localparam int PH_START = PH_W;
    localparam int LAT = 1;
`else
    localparam int PH_START = PH_F;
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] mem [16];
    int         m_ph = PH_START, n_ph = PH_START;
    logic [7:0] m_ir = '0, n_ir = '0;
    logic [3:0] m_pc = '0, n_pc = '0;
    int         passed = 0, total = 0, cyc = 0;

    control_sequencer_if #(.WIDTH(4), .OPW(4)) bus ();
    control_sequencer #(.WIDTH(4), .OPW(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    assign bus.instr = mem[m_pc];

    function automatic logic [15:0] outs();
        return {bus.mem_rd, bus.pc_enable, bus.pc_load, bus.pc_in, bus.acc_load,
                bus.alu_op, bus.operand, bus.halted};
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
    endtask

    // Instruction-level model: phase of the current instruction, IR and PC.
    always @(negedge clk) begin : model
        logic [3:0]  op, opnd;
        logic        take, go;
        logic [15:0] e;
        op   = m_ir[7:4];
        opnd = m_ir[3:0];
`ifdef SINGLE_STEP_EN
        go = bus.run || bus.step;
`else
        go = 1'b1;
`endif
        take = op == 4'h6 || (op == 4'h7 && bus.zero_flag) || (op == 4'h8 && bus.carry_flag);
        e = '0;
        if (!reset) begin
            e[4:1] = opnd;
            if (m_ph == PH_F) e[15:14] = 2'b11;
            if (m_ph == PH_E) begin
                if (op >= 4'd1 && op <= 4'd5) begin
                    e[8]   = 1'b1;
                    e[7:5] = 3'(op - 4'd1);
                end
                if (take) begin
                    e[13]   = 1'b1;
                    e[12:9] = opnd;
                end
                e[0] = op == 4'hF;
            end
            if (m_ph == PH_H) e[0] = 1'b1;
        end
        chk("cycle", outs(), e);
        n_ph = m_ph;
        n_ir = m_ir;
        n_pc = m_pc;
        if (reset) begin
            n_ph = PH_START;
            n_ir = '0;
            n_pc = '0;
        end else begin
            case (m_ph)
                PH_F: begin
                    n_ir = mem[m_pc];
                    n_pc = 4'(m_pc + 4'd1);
                    n_ph = PH_D;
                end
                PH_D: n_ph = PH_E;
                PH_E: begin
                    n_ph = (op == 4'hF) ? PH_H : (go ? PH_F : PH_W);
                    if (take) n_pc = opnd;
                end
                PH_W: n_ph = go ? PH_F : PH_W;
                default: ;
            endcase
        end
    end

    always @(posedge clk) begin
        m_ph <= n_ph;
        m_ir <= n_ir;
        m_pc <= n_pc;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int n);
        while (cyc < n + LAT) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic clear_mem();
        foreach (mem[i]) mem[i] = 8'h00;
    endtask

    task automatic restart();
        reset = 1'b1;
        @(negedge clk);
        chk("reset out", outs(), 16'h0000);
        tick();
        @(negedge clk);
        chk("reset out", outs(), 16'h0000);
        tick();
        reset = 1'b0;
        cyc = 0;
    endtask

    initial begin
        int pe, ac;
        clear_mem();
        bus.zero_flag  = 1'b0;
        bus.carry_flag = 1'b0;
`ifdef SINGLE_STEP_EN
        bus.run  = 1'b1;
        bus.step = 1'b0;
`endif
        tick();

        // LDA 3, ADD 4, HLT
        mem[0] = 8'h13; mem[1] = 8'h24; mem[2] = 8'hF0;
        restart();
        pe = 0; ac = 0;
        for (int c = 1; c <= 12; c++) begin
            step_to(c);
            pe += int'(bus.pc_enable);
            ac += int'(bus.acc_load);
            if (c == 1) chk("first fetch", 16'({bus.mem_rd, bus.pc_enable}), 16'h0003);
            if (c == 3) chk("lda exec", 16'({bus.acc_load, bus.alu_op, bus.operand}), 16'h0083);
            if (c == 6) chk("add exec", 16'({bus.acc_load, bus.alu_op, bus.operand}), 16'h0094);
            if (c == 9 || c == 12) chk("halted", 16'(bus.halted), 16'h0001);
        end
        chk("pc_enable count", 16'(pe), 16'd3);
        chk("acc_load count", 16'(ac), 16'd2);

        // JMP 0xA, target LDA 3
        clear_mem();
        mem[0] = 8'h6A; mem[10] = 8'h13;
        restart();
        step_to(3);
        chk("jmp exec", 16'({bus.pc_load, bus.pc_in, bus.pc_enable}), 16'h0034);
        step_to(4);
        chk("jmp target fetch", 16'(bus.mem_rd), 16'h0001);
        step_to(6);
        chk("jmp target lda", 16'({bus.acc_load, bus.operand}), 16'h0013);

        // JZ 5 / JC 5 with each flag low and high
        clear_mem();
        mem[0] = 8'h75;
        bus.zero_flag = 1'b0; bus.carry_flag = 1'b1;
        restart(); step_to(3);
        chk("jz not taken", 16'({bus.pc_load, bus.pc_in}), 16'h0000);
        bus.zero_flag = 1'b1; bus.carry_flag = 1'b0;
        restart(); step_to(3);
        chk("jz taken", 16'({bus.pc_load, bus.pc_in}), 16'h0015);
        mem[0] = 8'h85;
        restart(); step_to(3);
        chk("jc not taken", 16'({bus.pc_load, bus.pc_in}), 16'h0000);
        bus.zero_flag = 1'b0; bus.carry_flag = 1'b1;
        restart(); step_to(3);
        chk("jc taken", 16'({bus.pc_load, bus.pc_in}), 16'h0015);
        step_to(6);
        bus.carry_flag = 1'b0;

        // Reset in the ADD execute cycle, then opcode 0xB
        clear_mem();
        mem[0] = 8'h24; mem[1] = 8'hB7;
        restart();
        step_to(2);
        tick();
        reset = 1'b1;
        step_to(3);
        chk("reset in exec", outs(), 16'h0000);
        tick();
        reset = 1'b0;
        cyc = 0;
        step_to(1);
        chk("fetch after reset", 16'({bus.mem_rd, bus.pc_enable}), 16'h0003);
        step_to(6);
        chk("opcode b nop", outs(), 16'h000E);

        // PC wrap: JMP F, LDA 2 at F, then wraps to 0
        clear_mem();
        mem[0] = 8'h6F; mem[15] = 8'h12;
        restart();
        step_to(6);
        chk("wrap lda", 16'({bus.acc_load, bus.operand}), 16'h0012);
        step_to(9);
        chk("wrap jmp", 16'({bus.pc_load, bus.pc_in}), 16'h001F);
        step_to(12);

`ifdef SINGLE_STEP_EN
        clear_mem();
        mem[0] = 8'h13; mem[1] = 8'h24;
        bus.run = 1'b0;
        restart();
        pe = 0; ac = 0;
        for (int c = 1; c <= 10; c++) begin
            step_to(c);
            pe += int'(bus.mem_rd);
        end
        chk("idle mem_rd", 16'(pe), 16'd0);
        tick();
        bus.step = 1'b1;
        pe = 0;
        step_to(11);
        pe += int'(bus.pc_enable);
        tick();
        bus.step = 1'b0;
        for (int c = 12; c <= 20; c++) begin
            step_to(c);
            pe += int'(bus.pc_enable);
            ac += int'(bus.acc_load);
        end
        chk("step pc_enable", 16'(pe), 16'd1);
        chk("step acc_load", 16'(ac), 16'd1);
        chk("stalled again", 16'(bus.mem_rd), 16'h0000);
        bus.run = 1'b1;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
